// File: rtl/root_job_scheduler.sv
// root_job_scheduler
//   Shares one root engine (10b radicand, 3b degree -> 20b root) among
//   NUM_REQ requesters. Round-robin grant, one job in flight. The result goes
//   back tagged with the requester id. Jobs with degree 0 are rejected without
//   using the engine. A job is aborted if the engine does not answer within
//   TIMEOUT cycles.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/radicand/degree  packed per-requester job requests (slice i)
//   req_ready                  one-hot accept, combinational, only in IDLE
//   eng_in_valid/data_1/data_2 engine start strobe and operands
//   eng_out_valid/data         engine result
//   rsp_valid/id/data/err/timeout  one-cycle registered response
//   busy                       high whenever the FSM is not IDLE
module root_job_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned RAD_W = 10,
  localparam int unsigned DEG_W = 3,
  localparam int unsigned RES_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*RAD_W-1:0] req_radicand,
  input  logic [NUM_REQ*DEG_W-1:0] req_degree,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     eng_in_valid,
  output logic [RAD_W-1:0]         eng_in_data_1,
  output logic [DEG_W-1:0]         eng_in_data_2,
  input  logic                     eng_out_valid,
  input  logic [RES_W-1:0]         eng_out_data,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RES_W-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [DEG_W-1:0]   deg_q, deg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic               to_q, to_d;
  logic               eng_vld_q, eng_vld_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_to_q, rsp_to_d;
  logic               busy_q, busy_d;

  logic [RAD_W-1:0]   rad_arr [NUM_REQ];
  logic [DEG_W-1:0]   deg_arr [NUM_REQ];
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;

  // Unpack the per-requester operand slices
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rad_arr[gi] = req_radicand[gi*RAD_W +: RAD_W];
    assign deg_arr[gi] = req_degree[gi*DEG_W +: DEG_W];
  end

  // Round-robin pick: first requester at or after the pointer, wrapping
  always_comb begin : grant_sel
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req_valid[ID_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    rad_d       = rad_q;
    deg_d       = deg_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    to_d        = to_q;
    eng_vld_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    req_ready   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_id] = 1'b1;
          id_d  = grant_id;
          rad_d = rad_arr[grant_id];
          deg_d = deg_arr[grant_id];
          rr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          res_d = '0;
          to_d  = 1'b0;
          err_d = (deg_arr[grant_id] == '0);
          if (deg_arr[grant_id] == '0) begin
            state_d = S_RESP;
          end else begin
            state_d   = S_ISSUE;
            eng_vld_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts as a result
        if (eng_out_valid) begin
          res_d   = eng_out_data;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = res_q;
        rsp_err_d   = err_q;
        rsp_to_d    = to_q;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        // Engine may hold out_valid for several cycles; let it fall first
        if (!eng_out_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      rad_q       <= '0;
      deg_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      eng_vld_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      rad_q       <= rad_d;
      deg_q       <= deg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      err_q       <= err_d;
      to_q        <= to_d;
      eng_vld_q   <= eng_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      busy_q      <= busy_d;
    end
  end

  assign eng_in_valid  = eng_vld_q;
  assign eng_in_data_1 = rad_q;
  assign eng_in_data_2 = deg_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_timeout   = rsp_to_q;
  assign busy          = busy_q;

endmodule
